test_stream_checker: RTL and testbench

//  Consumes the output stream of the unit under test inside the test-unit bench.

---
 rtl/test_unit_pkg.sv | 14 +
 rtl/test_stream_checker_if.sv | 13 +
 rtl/test_unit_watchdog.sv | 25 ++
 rtl/test_stream_checker.sv | 119 +++++++++++
 tb/tb_test_stream_checker.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/test_unit_pkg.sv
// Shared types and widths for the test-unit bench blocks
// (stream checker, watchdog, future stimulus generator).
package test_unit_pkg;

    typedef enum logic [1:0] {
        CHK_IDLE,
        CHK_RUN,
        CHK_DONE
    } chk_state_t;

    localparam int unsigned ERR_CNT_W  = 16;
    localparam int unsigned BEAT_CNT_W = 32;

endpackage

// File: rtl/test_stream_checker_if.sv
// Checked AXI-Stream-style link: the source drives data/valid/last,
// and the checker drives ready.
interface test_stream_checker_if #(
    parameter int unsigned DSIZE = 32
);
    logic [DSIZE-1:0] in_tdata;
    logic             in_tvalid;
    logic             in_tlast;
    logic             in_tready;

    modport master (output in_tdata, output in_tvalid, output in_tlast, input  in_tready);
    modport slave  (input  in_tdata, input  in_tvalid, input  in_tlast, output in_tready);
endinterface

// File: rtl/test_unit_watchdog.sv
// No-progress watchdog: counts enabled cycles since the last clear and
// flags expiry on the TIMEOUT-th such cycle; a clear in that cycle wins.
module test_unit_watchdog #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clock,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (!rst_n || clear)
            cnt <= '0;
        else if (enable)
            cnt <= cnt + CW'(1);
    end

    assign expired = enable && !clear && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/test_stream_checker.sv
// Stream checker: compares each accepted beat with an incrementing pattern
// and PKT_LEN framing, counts errors and reports busy/done/pass.
module test_stream_checker
    import test_unit_pkg::*;
#(
    parameter int unsigned     DSIZE   = 32,
    parameter int unsigned     PKT_LEN = 16,
    parameter int unsigned     PKT_NUM = 4,
    parameter logic [DSIZE-1:0] SEED   = '0,
    parameter int unsigned     TIMEOUT = 1024
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  start,
    test_stream_checker_if.slave  stream,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [ERR_CNT_W-1:0]  err_cnt,
    output logic [BEAT_CNT_W-1:0] beat_cnt,
    output logic [DSIZE-1:0]      first_err_data,
    output logic [DSIZE-1:0]      first_err_expect
);
    localparam int unsigned BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int unsigned PW = (PKT_NUM > 1) ? $clog2(PKT_NUM) : 1;

    chk_state_t       state, state_next;
    logic [DSIZE-1:0] expected;
    logic [BW-1:0]    beat_idx;
    logic [PW-1:0]    pkt_idx;
    logic             hs, start_run, exp_last, beat_err, final_beat, wd_expired;

    assign hs         = stream.in_tvalid && stream.in_tready;
    assign start_run  = start && (state != CHK_RUN);
    assign exp_last   = (beat_idx == BW'(PKT_LEN - 1));
    assign beat_err   = hs && ((stream.in_tdata != expected) || (stream.in_tlast != exp_last));
    assign final_beat = hs && exp_last && (pkt_idx == PW'(PKT_NUM - 1));

    test_unit_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clock   (clock),
        .rst_n   (rst_n),
        .clear   (hs || start_run),
        .enable  (state == CHK_RUN),
        .expired (wd_expired)
    );

    always_ff @(posedge clock) begin
        if (!rst_n)
            state <= CHK_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            CHK_IDLE, CHK_DONE: if (start) state_next = CHK_RUN;
            CHK_RUN:            if (final_beat || wd_expired) state_next = CHK_DONE;
            default:            state_next = CHK_IDLE;
        endcase
    end

    assign busy = (state == CHK_RUN);
    assign done = (state == CHK_DONE);

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            stream.in_tready <= 1'b0;
            expected         <= '0;
            beat_idx         <= '0;
            pkt_idx          <= '0;
            err_cnt          <= '0;
            beat_cnt         <= '0;
            pass             <= 1'b0;
            timeout          <= 1'b0;
            first_err_data   <= '0;
            first_err_expect <= '0;
        end else begin
            // ready tracks the next state so it drops on the same edge RUN is left
            stream.in_tready <= (state_next == CHK_RUN);
            if (start_run) begin
                expected         <= SEED;
                beat_idx         <= '0;
                pkt_idx          <= '0;
                err_cnt          <= '0;
                beat_cnt         <= '0;
                pass             <= 1'b0;
                timeout          <= 1'b0;
                first_err_data   <= '0;
                first_err_expect <= '0;
            end else if (state == CHK_RUN) begin
                if (hs) begin
                    expected <= expected + DSIZE'(1);
                    beat_cnt <= beat_cnt + BEAT_CNT_W'(1);
                    if (exp_last) begin
                        beat_idx <= '0;
                        pkt_idx  <= pkt_idx + PW'(1);
                    end else begin
                        beat_idx <= beat_idx + BW'(1);
                    end
                    if (beat_err) begin
                        if (err_cnt != '1)
                            err_cnt <= err_cnt + ERR_CNT_W'(1);
                        if (err_cnt == '0) begin
                            first_err_data   <= stream.in_tdata;
                            first_err_expect <= expected;
                        end
                    end
                end
                if (wd_expired)
                    timeout <= 1'b1;
                if (state_next == CHK_DONE)
                    pass <= (err_cnt == '0) && !beat_err && !wd_expired;
            end
        end
    end

endmodule

// File: tb/tb_test_stream_checker.sv
// Directed bench for test_stream_checker: default, short-timeout and
// wrapping-seed instances share one stimulus driver selected by sel.
module tb_test_stream_checker;
    import test_unit_pkg::*;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] tdata = '0;
    logic        tvalid = 1'b0;
    logic        tlast = 1'b0;
    int          sel = 0;
    int          tests = 0;
    int          fails = 0;

    logic        busy_a [3];
    logic        done_a [3];
    logic        pass_a [3];
    logic        tout_a [3];
    logic [15:0] err_a  [3];
    logic [31:0] beat_a [3];
    logic [31:0] fed_a  [3];
    logic [31:0] fee_a  [3];
    logic        rdy_a  [3];
    logic        rdy;

    always #5 clock = ~clock;

    test_stream_checker_if #(.DSIZE(32)) if0 ();
    test_stream_checker_if #(.DSIZE(32)) if1 ();
    test_stream_checker_if #(.DSIZE(32)) if2 ();

    assign if0.in_tdata  = tdata;
    assign if0.in_tlast  = tlast;
    assign if0.in_tvalid = tvalid && (sel == 0);
    assign if1.in_tdata  = tdata;
    assign if1.in_tlast  = tlast;
    assign if1.in_tvalid = tvalid && (sel == 1);
    assign if2.in_tdata  = tdata;
    assign if2.in_tlast  = tlast;
    assign if2.in_tvalid = tvalid && (sel == 2);
    assign rdy_a[0] = if0.in_tready;
    assign rdy_a[1] = if1.in_tready;
    assign rdy_a[2] = if2.in_tready;
    assign rdy      = rdy_a[sel];

    test_stream_checker dut (
        .clock(clock), .rst_n(rst_n), .start(start && (sel == 0)), .stream(if0.slave),
        .busy(busy_a[0]), .done(done_a[0]), .pass(pass_a[0]), .timeout(tout_a[0]),
        .err_cnt(err_a[0]), .beat_cnt(beat_a[0]),
        .first_err_data(fed_a[0]), .first_err_expect(fee_a[0])
    );

    test_stream_checker #(.TIMEOUT(8)) dut_to (
        .clock(clock), .rst_n(rst_n), .start(start && (sel == 1)), .stream(if1.slave),
        .busy(busy_a[1]), .done(done_a[1]), .pass(pass_a[1]), .timeout(tout_a[1]),
        .err_cnt(err_a[1]), .beat_cnt(beat_a[1]),
        .first_err_data(fed_a[1]), .first_err_expect(fee_a[1])
    );

    test_stream_checker #(.SEED(32'hFFFF_FFFE)) dut_seed (
        .clock(clock), .rst_n(rst_n), .start(start && (sel == 2)), .stream(if2.slave),
        .busy(busy_a[2]), .done(done_a[2]), .pass(pass_a[2]), .timeout(tout_a[2]),
        .err_cnt(err_a[2]), .beat_cnt(beat_a[2]),
        .first_err_data(fed_a[2]), .first_err_expect(fee_a[2])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // one beat: hold valid until the selected checker is ready, then one edge
    task automatic send(input logic [31:0] d, input logic l);
        int unsigned n = 0;
        tdata  = d;
        tlast  = l;
        tvalid = 1'b1;
        while (!rdy && n < 64) begin
            tick();
            n++;
        end
        if (n >= 64) check("send_rdy_wait", rdy, 1'b1);
        tick();
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy_a[sel], 0);
        check({tag, "_done"}, done_a[sel], 0);
        check({tag, "_pass"}, pass_a[sel], 0);
        check({tag, "_tout"}, tout_a[sel], 0);
        check({tag, "_err"},  err_a[sel],  0);
        check({tag, "_beat"}, beat_a[sel], 0);
        check({tag, "_fed"},  fed_a[sel],  0);
        check({tag, "_fee"},  fee_a[sel],  0);
        check({tag, "_rdy"},  rdy,         0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed simulation still running expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int unsigned n;
        logic [31:0] d;
        logic        l;

        // reset state
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        sel = 0;
        check_zero("reset");

        // 1: clean 64-beat run
        pulse_start();
        check("t1_busy", busy_a[0], 1);
        check("t1_rdy",  rdy,       1);
        for (int i = 0; i < 64; i++) send(32'(i), (i % 16) == 15);
        check("t1_done", done_a[0], 1);
        check("t1_busy_off", busy_a[0], 0);
        check("t1_pass", pass_a[0], 1);
        check("t1_err",  err_a[0],  0);
        check("t1_beat", beat_a[0], 64);
        check("t1_rdy_off", rdy, 0);

        // 2: one data error on beat 20
        pulse_start();
        check("t2_pass_cleared", pass_a[0], 0);
        for (int i = 0; i < 64; i++) send((i == 20) ? 32'hDEAD : 32'(i), (i % 16) == 15);
        check("t2_done", done_a[0], 1);
        check("t2_err",  err_a[0],  1);
        check("t2_fed",  fed_a[0],  32'hDEAD);
        check("t2_fee",  fee_a[0],  20);
        check("t2_pass", pass_a[0], 0);

        // 3: tlast missing on beat 15, stray tlast on beat 16
        pulse_start();
        check("t3_err_cleared", err_a[0], 0);
        for (int i = 0; i < 64; i++) begin
            l = ((i % 16) == 15);
            if (i == 15) l = 1'b0;
            if (i == 16) l = 1'b1;
            send(32'(i), l);
        end
        check("t3_err",  err_a[0],  2);
        check("t3_fed",  fed_a[0],  15);
        check("t3_fee",  fee_a[0],  15);
        check("t3_pass", pass_a[0], 0);
        check("t3_beat", beat_a[0], 64);

        // extra beats after DONE are back-pressured
        tvalid = 1'b1;
        tdata  = 32'd64;
        repeat (3) tick();
        tvalid = 1'b0;
        check("t3_extra_beat", beat_a[0], 64);
        check("t3_extra_rdy",  rdy,       0);
        check("t3_extra_done", done_a[0], 1);

        // 4: watchdog, TIMEOUT=8, source stalls after 10 beats
        sel = 1;
        pulse_start();
        for (int i = 0; i < 10; i++) send(32'(i), 1'b0);
        n = 0;
        while (!done_a[1] && n < 100) begin
            tick();
            n++;
        end
        check("t4_expiry_cycles", n, 8);
        check("t4_tout", tout_a[1], 1);
        check("t4_done", done_a[1], 1);
        check("t4_pass", pass_a[1], 0);
        check("t4_beat", beat_a[1], 10);
        check("t4_err",  err_a[1],  0);
        check("t4_rdy",  rdy,       0);

        // 5: reset mid-run at beat 30, then a clean run
        sel = 0;
        pulse_start();
        for (int i = 0; i < 30; i++) send(32'(i), (i % 16) == 15);
        check("t5_mid_beat", beat_a[0], 30);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_zero("t5_reset");
        pulse_start();
        for (int i = 0; i < 64; i++) send(32'(i), (i % 16) == 15);
        check("t5_done", done_a[0], 1);
        check("t5_pass", pass_a[0], 1);
        check("t5_beat", beat_a[0], 64);

        // 6: seed wraps past zero, random gaps, start ignored mid-run
        sel = 2;
        pulse_start();
        for (int i = 0; i < 64; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            d = 32'hFFFF_FFFE + 32'(i);
            send(d, (i % 16) == 15);
            if (i == 3) check("t6_wrap_err", err_a[2], 0);
            if (i == 9) begin
                pulse_start();
                check("t6_start_busy", busy_a[2], 1);
                check("t6_start_beat", beat_a[2], 10);
            end
        end
        check("t6_done", done_a[2], 1);
        check("t6_pass", pass_a[2], 1);
        check("t6_err",  err_a[2],  0);
        check("t6_beat", beat_a[2], 64);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
